// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC controller for the RV32IM ProgramCounter register.
//            It selects among sequential, redirect, trap and mret sources.
//            Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirects
//            into traps.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int               PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_we_o,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  input  logic            fetch_ack_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_req_i,
  output logic            flush_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            misalign_fault_o
);

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    FETCH_S = 2'd1,
    HOLD_S  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_S;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
    end
  end

  assign fetch_addr_o = pc_cur_i;
  assign mepc_o       = mepc_q;

  always_comb begin
    state_d          = state_q;
    mepc_d           = mepc_q;
    pc_next_o        = pc_cur_i;
    pc_we_o          = 1'b0;
    fetch_req_o      = 1'b0;
    flush_o          = 1'b0;
    misalign_fault_o = 1'b0;

    if (rst) begin
      pc_next_o = RESET_VECTOR;
    end else begin
      case (state_q)
        RESET_S: begin
          pc_we_o   = 1'b1;
          pc_next_o = RESET_VECTOR;
          state_d   = FETCH_S;
        end
        FETCH_S, HOLD_S: begin
          state_d = FETCH_S;
          // Control events win over stall and discard any same-cycle fetch_ack.
          if (trap_req_i) begin
            pc_next_o = TRAP_VECTOR;
            pc_we_o   = 1'b1;
            flush_o   = 1'b1;
            mepc_d    = trap_pc_i;
          end else if (mret_req_i) begin
            pc_next_o = mepc_q;
            pc_we_o   = 1'b1;
            flush_o   = 1'b1;
          end else if (redirect_valid_i) begin
            pc_we_o = 1'b1;
            flush_o = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (redirect_target_i[1:0] != 2'b00) begin
              pc_next_o        = TRAP_VECTOR;
              mepc_d           = pc_cur_i;
              misalign_fault_o = 1'b1;
            end else begin
              pc_next_o = redirect_target_i;
            end
`else
            pc_next_o = redirect_target_i & ~XLEN'(3);
`endif
          end else if (stall_i) begin
            state_d = HOLD_S;
          end else if (state_q == FETCH_S) begin
            fetch_req_o = 1'b1;
            if (fetch_ack_i) begin
              pc_we_o   = 1'b1;
              pc_next_o = pc_cur_i + XLEN'(PC_STEP);
            end
          end
        end
        default: state_d = RESET_S;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with directed scenarios and
//            a randomized run against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q = 32'hDEAD_BEE0;
  logic [31:0] pc_next, fetch_addr, redirect_target, trap_pc, mepc;
  logic        pc_we, fetch_req, fetch_ack, stall, redirect_valid;
  logic        trap_req, mret_req, flush, misalign_fault;
  int          checks = 0;
  int          failures = 0;

  initial forever #5 clk = ~clk;

  // Stand-in for the ProgramCounter register the sequencer controls.
  always_ff @(posedge clk) if (pc_we) pc_q <= pc_next;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_cur_i(pc_q), .pc_next_o(pc_next), .pc_we_o(pc_we),
    .fetch_req_o(fetch_req), .fetch_addr_o(fetch_addr), .fetch_ack_i(fetch_ack),
    .stall_i(stall), .redirect_valid_i(redirect_valid),
    .redirect_target_i(redirect_target), .trap_req_i(trap_req),
    .trap_pc_i(trap_pc), .mret_req_i(mret_req), .flush_o(flush),
    .mepc_o(mepc), .misalign_fault_o(misalign_fault)
  );

  task automatic drive(input logic r, input logic a, input logic s, input logic rv,
                       input logic [31:0] rt, input logic tr, input logic [31:0] tp,
                       input logic m);
    @(negedge clk);
    rst = r; fetch_ack = a; stall = s; redirect_valid = rv;
    redirect_target = rt; trap_req = tr; trap_pc = tp; mret_req = m;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_we, fetch_req, flush, misalign_fault} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outs got=%b want=0000", {pc_we, fetch_req, flush, misalign_fault});
    end
    checks++;
    if (mepc !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h want=0", mepc); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_we, fetch_req, flush, pc_next} !== {3'b100, RV}) begin
      failures++;
      $display("FAIL reset_load got=%b/%h want=100/%h", {pc_we, fetch_req, flush}, pc_next, RV);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({fetch_req, pc_we, fetch_addr, pc_next} !== {2'b11, 32'(i * 4), 32'(i * 4 + 4)}) begin
        failures++;
        $display("FAIL seq_fetch%0d got=%b/%h/%h want=11/%h/%h", i, {fetch_req, pc_we},
                 fetch_addr, pc_next, 32'(i * 4), 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 0, 1, 32'h10, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      checks++;
      if ({fetch_req, pc_we, fetch_addr} !== {2'b00, 32'h10}) begin
        failures++;
        $display("FAIL stall%0d got=%b/%h want=00/00000010", i, {fetch_req, pc_we}, fetch_addr);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_req, pc_we} !== 2'b00) begin
      failures++; $display("FAIL stall_release got=%b want=00", {fetch_req, pc_we});
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_req, pc_we, fetch_addr, pc_next} !== {2'b11, 32'h10, 32'h14}) begin
      failures++;
      $display("FAIL stall_resume got=%b/%h/%h want=11/10/14", {fetch_req, pc_we}, fetch_addr, pc_next);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 32'h14}) begin
      failures++; $display("FAIL stall_next got=%b/%h want=1/14", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_redirect_collision();
    drive(0, 1, 1, 1, 32'h200, 0, 0, 0);
    checks++;
    if ({pc_we, fetch_req, flush, pc_next} !== {3'b101, 32'h200}) begin
      failures++;
      $display("FAIL redir_coll got=%b/%h want=101/200", {pc_we, fetch_req, flush}, pc_next);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_req, flush, fetch_addr} !== {2'b10, 32'h200}) begin
      failures++; $display("FAIL redir_fetch got=%b/%h want=10/200", {fetch_req, flush}, fetch_addr);
    end
  endtask

  task automatic test_trap_mret();
    drive(0, 1, 0, 1, 32'h300, 1, 32'h44, 0);
    checks++;
    if ({pc_we, fetch_req, flush, misalign_fault, pc_next} !== {4'b1010, TV}) begin
      failures++;
      $display("FAIL trap got=%b/%h want=1010/%h", {pc_we, fetch_req, flush, misalign_fault}, pc_next, TV);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mepc, fetch_addr, fetch_req} !== {32'h44, TV, 1'b1}) begin
      failures++; $display("FAIL trap_after got=%h/%h/%b want=44/%h/1", mepc, fetch_addr, fetch_req, TV);
    end
    drive(0, 1, 0, 1, 32'h400, 0, 0, 1);
    checks++;
    if ({pc_we, fetch_req, flush, pc_next} !== {3'b101, 32'h44}) begin
      failures++; $display("FAIL mret got=%b/%h want=101/44", {pc_we, fetch_req, flush}, pc_next);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_addr, mepc} !== {32'h44, 32'h44}) begin
      failures++; $display("FAIL mret_after got=%h/%h want=44/44", fetch_addr, mepc);
    end
  endtask

  task automatic test_wrap_reset();
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_addr, pc_we, pc_next} !== {32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      failures++; $display("FAIL wrap got=%h/%b/%h want=fffffffc/1/0", fetch_addr, pc_we, pc_next);
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 32'h500, 0, 0, 0);
    checks++;
    if ({pc_we, fetch_req, flush, misalign_fault} !== 4'b0000) begin
      failures++;
      $display("FAIL midop_rst got=%b want=0000", {pc_we, fetch_req, flush, misalign_fault});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mepc, pc_we, fetch_req, pc_next} !== {32'h0, 2'b10, RV}) begin
      failures++;
      $display("FAIL midop_restart got=%h/%b/%h want=0/10/%h", mepc, {pc_we, fetch_req}, pc_next, RV);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, RV}) begin
      failures++; $display("FAIL midop_fetch got=%b/%h want=1/%h", fetch_req, fetch_addr, RV);
    end
  endtask

  task automatic test_misalign();
    drive(0, 0, 0, 1, 32'h80, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h202, 0, 0, 0);
    checks++;
`ifdef PC_MISALIGN_TRAP_EN
    if ({pc_we, flush, misalign_fault, pc_next} !== {3'b111, TV}) begin
      failures++; $display("FAIL misalign got=%b/%h want=111/%h", {pc_we, flush, misalign_fault}, pc_next, TV);
    end
`else
    if ({pc_we, flush, misalign_fault, pc_next} !== {3'b110, 32'h200}) begin
      failures++; $display("FAIL misalign got=%b/%h want=110/200", {pc_we, flush, misalign_fault}, pc_next);
    end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
`ifdef PC_MISALIGN_TRAP_EN
    if ({mepc, fetch_addr, misalign_fault} !== {32'h80, TV, 1'b0}) begin
      failures++; $display("FAIL misalign_after got=%h/%h/%b want=80/%h/0", mepc, fetch_addr, misalign_fault, TV);
    end
`else
    if ({mepc, fetch_addr, misalign_fault} !== {32'h0, 32'h200, 1'b0}) begin
      failures++; $display("FAIL misalign_after got=%h/%h/%b want=0/200/0", mepc, fetch_addr, misalign_fault);
    end
`endif
  endtask

  task automatic test_random();
    int          ph;            // 0: reset load pending, 1: fetching, 2: holding
    int          n_ph;
    logic [31:0] m_pc, m_mepc, n_mepc, e_next, rt, tp;
    logic        e_we, e_req, e_flush, e_mis, r, a, s, rv, tr, m;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ph = 1; m_pc = RV; m_mepc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      tr = ($urandom_range(0, 15) == 0);
      m  = ($urandom_range(0, 15) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rt = $urandom;
      if ($urandom_range(0, 2) != 0) rt = rt - (rt % 4);
      s  = ($urandom_range(0, 3) == 0);
      a  = 1'($urandom_range(0, 1));
      tp = $urandom;
      drive(r, a, s, rv, rt, tr, tp, m);

      e_we = 0; e_req = 0; e_flush = 0; e_mis = 0; e_next = m_pc;
      n_ph = ph; n_mepc = m_mepc;
      if (r) begin
        n_ph = 0; n_mepc = 32'h0;
      end else if (ph == 0) begin
        e_we = 1; e_next = RV; n_ph = 1;
      end else if (tr) begin
        e_we = 1; e_flush = 1; e_next = TV; n_mepc = tp; n_ph = 1;
      end else if (m) begin
        e_we = 1; e_flush = 1; e_next = m_mepc; n_ph = 1;
      end else if (rv) begin
        e_we = 1; e_flush = 1; n_ph = 1;
`ifdef PC_MISALIGN_TRAP_EN
        if (rt % 4 != 0) begin
          e_next = TV; n_mepc = m_pc; e_mis = 1;
        end else begin
          e_next = rt;
        end
`else
        e_next = rt - (rt % 4);
`endif
      end else if (s) begin
        n_ph = 2;
      end else if (ph == 2) begin
        n_ph = 1;
      end else begin
        e_req = 1;
        if (a) begin e_we = 1; e_next = m_pc + 32'd4; end
      end

      checks++;
      if (fetch_addr !== m_pc) begin
        failures++; $display("FAIL rnd%0d fetch_addr got=%h want=%h", i, fetch_addr, m_pc);
      end
      checks++;
      if (mepc !== m_mepc) begin
        failures++; $display("FAIL rnd%0d mepc got=%h want=%h", i, mepc, m_mepc);
      end
      checks++;
      if ({pc_we, fetch_req, flush, misalign_fault} !== {e_we, e_req, e_flush, e_mis}) begin
        failures++;
        $display("FAIL rnd%0d ctrl got=%b want=%b", i, {pc_we, fetch_req, flush, misalign_fault},
                 {e_we, e_req, e_flush, e_mis});
      end
      if (e_we) begin
        checks++;
        if (pc_next !== e_next) begin
          failures++; $display("FAIL rnd%0d pc_next got=%h want=%h", i, pc_next, e_next);
        end
      end
      if (e_we) m_pc = e_next;
      ph = n_ph; m_mepc = n_mepc;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_ack = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
    trap_req = 0; trap_pc = 0; mret_req = 0;
    test_reset();
    test_stall();
    test_redirect_collision();
    test_trap_mret();
    test_wrap_reset();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller that sequences the ProgramCounter register in the RV32IM core. Each cycle it chooses the next PC from one of four sources: sequential +STEP, branch/jump redirect, trap vector, or mret return. It drives the register's load value and write enable, and issues instruction-fetch requests from the current PC. It also holds mepc internally and handles stalls, flushes and fault-on-misaligned-target.

Parameters:
XLEN, 32, PC/address width
RESET_VECTOR, 32'h0000_0000, PC loaded after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap (fixed mtvec)
PC_STEP, 4, sequential increment

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pc_cur  in  XLEN  current PC from ProgramCounter outPC
pc_next  out  XLEN  load value to ProgramCounter inPC
pc_we  out  1  ProgramCounter write enable
fetch_req  out  1  instruction fetch request
fetch_addr  out  XLEN  fetch address (= pc_cur)
fetch_ack  in  1  imem returned instruction this cycle; only meaningful while fetch_req=1
stall  in  1  backend hold (e.g. divider busy)
redirect_valid  in  1  taken branch/jump from execute
redirect_target  in  XLEN  redirect destination
trap_req  in  1  exception/interrupt taken
trap_pc  in  XLEN  PC of faulting instruction, saved to mepc
mret_req  in  1  return from trap
flush  out  1  pulse: discard in-flight fetch/decode
mepc  out  XLEN  saved trap PC
misalign_fault  out  1  pulse: misaligned redirect trapped

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- States: RESET_S, FETCH_S, HOLD_S.
- While rst=1, at the next edge: state←RESET_S, mepc←0.
  - Combinational outputs while state=RESET_S: pc_we=0 during rst, fetch_req=0, flush=0, misalign_fault=0, pc_next=RESET_VECTOR.
- RESET_S with rst=0: pc_we=1, pc_next=RESET_VECTOR, fetch_req=0; next state FETCH_S. trap/mret/redirect are ignored in this state.
- FETCH_S: fetch_req=!stall; fetch_addr=pc_cur.
  - fetch_ack=1 and stall=0: pc_we=1, pc_next=pc_cur+PC_STEP, modulo 2^XLEN (0xFFFF_FFFC → 0x0000_0000).
  - fetch_ack=0: pc_we=0, stay in FETCH_S.
  - stall=1: pc_we=0, next state HOLD_S.
- HOLD_S: fetch_req=0, pc_we=0. When stall=0, go to FETCH_S next cycle.
- Control events, evaluated in FETCH_S and HOLD_S, take effect in the same cycle. Priority is trap_req > mret_req > redirect_valid > stall > sequential.
  - trap_req: pc_next=TRAP_VECTOR, pc_we=1, flush=1, mepc←trap_pc, fetch_req=0; next state FETCH_S.
  - mret_req: pc_next=mepc (value before any same-cycle update), pc_we=1, flush=1, fetch_req=0; next state FETCH_S.
  - redirect_valid: pc_next=redirect_target, pc_we=1, flush=1, fetch_req=0; next state FETCH_S.
  - A fetch_ack arriving in the same cycle as a control event is discarded and does not advance the PC.
  - Control events override stall: stall only blocks sequential advance.
- After any control event, the first fetch_req asserts the following cycle at the new pc_cur, provided stall=0.
- flush and misalign_fault are single-cycle, combinational from the event inputs gated by state.
- Reset asserted mid-operation (any state): pc_we=0 and fetch_req=0 immediately; at the edge the FSM returns to RESET_S and mepc is cleared. A pending stall/redirect is lost.
- No outputs are X after the first reset edge.

Optional Feature:
Macro: PC_MISALIGN_TRAP_EN
- Defined:
  - redirect_valid with redirect_target[1:0]≠0 (and no trap_req) is converted to a trap: pc_next=TRAP_VECTOR, mepc←pc_cur, flush=1, misalign_fault=1.
  - mret_req still outranks it.
- Undefined:
  - misalign_fault is tied 0.
  - Redirect uses {redirect_target[XLEN-1:2],2'b00}.

Test Plan:
1. Reset release and sequential fetch: rst=1 for 2 cycles then 0; fetch_ack held 1 → pc_we=1/pc_next=0 one cycle after release, then fetch_addr 0x0, 0x4, 0x8 on consecutive cycles.
2. Stall: at pc=0x10, stall=1 for 3 cycles → fetch_req=0, pc_we=0, pc stays 0x10; stall=0 → fetch_req resumes at 0x10 next cycle, then 0x14.
3. Redirect during fetch_ack and stall: redirect_valid=1, target 0x200, fetch_ack=1, stall=1 same cycle → pc_next=0x200, flush=1, no +4; next fetch_addr 0x200 once stall drops.
4. Trap and mret: trap_req with trap_pc=0x44 and redirect_valid=1 simultaneously → pc_next=0x100, mepc=0x44; later mret_req → pc_next=0x44, flush=1.
5. Wrap and mid-op reset: pc_cur=0xFFFF_FFFC with fetch_ack → pc_next=0x0; assert rst while in HOLD_S → pc_we=0, mepc=0, restart at RESET_VECTOR.
6. Misaligned redirect, target 0x202 at pc_cur=0x80: with PC_MISALIGN_TRAP_EN → pc_next=0x100, mepc=0x80, misalign_fault=1; without → pc_next=0x200, misalign_fault=0.
